// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined immediate encoder.
// Writes a two's-complement immediate into the bit fields of an instruction
// template for the selected immediate format. Template bits outside the
// format's fields pass through unchanged.
// Optional feature macro: IMM_ENC_RANGE_CHECK_EN. When defined, each beat is
// checked for exact representability (range and alignment), flagged on
// out_range_err and counted in a saturating err_count. When undefined both
// outputs are tied to zero; encoding and truncation are identical either way.

module imm_encoder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  input  logic [2:0]               in_imm_src,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic                     out_range_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [2:0]  s1_src;
  logic [31:0] s1_imm;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_ready;
  logic        in_fire;
  logic [31:0] merged;

  // Scatter the immediate into the selected format's instruction fields.
  // Formats 110 and 111 fall through to the I layout.
  function automatic logic [31:0] encode(input logic [31:0] tmpl,
                                         input logic [2:0]  src,
                                         input logic [31:0] imm);
    logic [31:0] r;
    r = tmpl;
    case (src)
      3'b001: r[28:14] = imm[14:0];
      3'b010: begin
        r[28:19] = imm[14:5];
        r[4:0]   = imm[4:0];
      end
      3'b011: begin
        r[28:13] = imm[27:12];
        r[9:0]   = imm[11:2];
      end
      3'b100: r[28:13] = imm[17:2];
      3'b101: r[28:9]  = imm[31:12];
      default: r[27:14] = imm[13:0];
    endcase
    return r;
  endfunction

  // A stage can take a new beat when it is empty or its contents are leaving.
  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_instr = s2_instr;

  // Stage 1: capture template, format and immediate on an input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_src   <= '0;
      s1_imm   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_instr <= in_instr;
      s1_src   <= in_imm_src;
      s1_imm   <= in_imm;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Field merge happens between the stages so the output is a pure register.
  always_comb begin
    merged = encode(s1_instr, s1_src, s1_imm);
  end

  // Stage 2: register the merged instruction; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= merged;
      end
    end
  end

`ifdef IMM_ENC_RANGE_CHECK_EN

  logic                     s1_err;
  logic                     s2_err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // Representable means every bit above the field's top bit equals the sign,
  // and any implicit low zero bits really are zero.
  function automatic logic is_legal(input logic [2:0]  src,
                                    input logic [31:0] imm);
    logic ok;
    case (src)
      3'b001, 3'b010: ok = (&imm[31:14]) || !(|imm[31:14]);
      3'b011: ok = ((&imm[31:27]) || !(|imm[31:27])) && (imm[1:0] == 2'b00);
      3'b100: ok = ((&imm[31:17]) || !(|imm[31:17])) && (imm[1:0] == 2'b00);
      3'b101: ok = (imm[11:0] == 12'h000);
      default: ok = (&imm[31:13]) || !(|imm[31:13]);
    endcase
    return ok;
  endfunction

  // Legality is judged on the raw input and travels alongside the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err <= 1'b0;
    end else if (in_fire) begin
      s1_err <= !is_legal(in_imm_src, in_imm);
    end
  end

  // Error flag follows its beat into stage 2 under the same load condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_err <= 1'b0;
    end else if (s2_ready && s1_valid) begin
      s2_err <= s1_err;
    end
  end

  // Count flagged beats as they leave; stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (s2_valid && out_ready && s2_err && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign out_range_err = s2_err;
  assign err_count     = err_cnt_q;

`else

  assign out_range_err = 1'b0;
  assign err_count     = '0;

`endif

endmodule
